hs_sender: RTL and testbench

//  Transmit end of the 16-bit valid/ready word handshake used between blocks.

---
 rtl/hs_pkg.sv | 22 ++
 rtl/hs_sync_fifo.sv | 58 +++++
 rtl/hs_sender.sv | 107 ++++++++++
 tb/tb_hs_sender.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/hs_pkg.sv
// Shared definitions for the valid/ready word handshake blocks.
package hs_pkg;

  localparam int unsigned HS_DW = 16;

  // Sender output state: StIdle drives valid=0, StSend drives valid=1.
  typedef enum logic [0:0] {
    StIdle,
    StSend
  } hs_state_e;

  // Ceiling log2, usable in constant expressions for port widths.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hs_sync_fifo.sv
// Small synchronous FIFO with occupancy count; DEPTH must be a power of two.
module hs_sync_fifo
  import hs_pkg::*;
#(
  parameter int unsigned DW    = HS_DW,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [DW-1:0]          wr_data,
  input  logic                   rd_en,
  output logic [DW-1:0]          rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  level
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          do_wr, do_rd;

  // full/empty come from the registered count, so a write while full is
  // dropped even if a read frees a slot on the same edge.
  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;

  // Storage array; no reset needed since contents are gated by level.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  // Pointers wrap naturally at the power-of-two depth; level tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_wr && !do_rd) begin
        level_q <= level_q + LW'(1);
      end else if (do_rd && !do_wr) begin
        level_q <= level_q - LW'(1);
      end
    end
  end

endmodule

// File: rtl/hs_sender.sv
// Transmit side of the valid/ready word handshake: FIFO, output register,
// IDLE/SEND FSM, transfer counter and sticky stall timeout.
module hs_sender
  import hs_pkg::*;
#(
  parameter int unsigned DW          = HS_DW,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [DW-1:0]          wr_data,
  output logic                   full,
  output logic                   overflow,
  output logic                   valid,
  output logic [DW-1:0]          data,
  input  logic                   ready,
  output logic [clog2(DEPTH):0]  level,
  output logic [15:0]            tx_count,
  output logic                   timeout,
  input  logic                   tmo_clr
);

  localparam int unsigned SW = clog2(TIMEOUT_CYC + 1);

  hs_state_e     state_q, state_d;
  logic [DW-1:0] data_q;
  logic          overflow_q;
  logic [15:0]   tx_count_q;
  logic [SW-1:0] stall_q, stall_d;
  logic          timeout_q, timeout_d;

  logic          fifo_empty, fifo_full;
  logic [DW-1:0] fifo_rdata;
  logic          xfer, pop;

  assign valid    = (state_q == StSend);
  assign data     = data_q;
  assign overflow = overflow_q;
  assign tx_count = tx_count_q;
  assign timeout  = timeout_q;
  assign full     = fifo_full;

  assign xfer = valid & ready;
  // Refill the output register whenever it is empty or being emptied.
  assign pop  = ~fifo_empty & (~valid | xfer);

  hs_sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  // Next-state for the output FSM and the stall/timeout tracker.
  always_comb begin
    state_d   = state_q;
    stall_d   = stall_q;
    timeout_d = timeout_q;

    unique case (state_q)
      StIdle: if (!fifo_empty) state_d = StSend;
      StSend: if (xfer && fifo_empty) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (tmo_clr) begin
      stall_d   = '0;
      timeout_d = 1'b0;
    end else if (xfer) begin
      stall_d = '0;
    end else if (valid) begin
      // Saturate at the threshold so a long stall cannot wrap the counter.
      if (stall_q != SW'(TIMEOUT_CYC)) stall_d = stall_q + SW'(1);
      if (stall_d == SW'(TIMEOUT_CYC)) timeout_d = 1'b1;
    end
  end

  // State, output register and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      data_q     <= '0;
      overflow_q <= 1'b0;
      tx_count_q <= '0;
      stall_q    <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      stall_q    <= stall_d;
      timeout_q  <= timeout_d;
      overflow_q <= wr_en & fifo_full;
      if (pop)  data_q     <= fifo_rdata;
      if (xfer) tx_count_q <= tx_count_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_hs_sender.sv
// Self-checking bench for hs_sender against a queue-based reference model.
module tb_hs_sender;

  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        full;
  logic        overflow;
  logic        valid;
  logic [15:0] data;
  logic        ready;
  logic [2:0]  level;
  logic [15:0] tx_count;
  logic        timeout;
  logic        tmo_clr;

  int n_vec;
  int n_err;

  // Reference model: FIFO contents as a queue plus the word on the wire.
  logic [15:0] m_q [$];
  bit          m_v;
  logic [15:0] m_d;
  int          m_tx;
  bit          m_ovf;
  int          m_stall;
  bit          m_tmo;

  hs_sender #(
    .DW          (16),
    .DEPTH       (DEPTH),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .overflow (overflow),
    .valid    (valid),
    .data     (data),
    .ready    (ready),
    .level    (level),
    .tx_count (tx_count),
    .timeout  (timeout),
    .tmo_clr  (tmo_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_v     = 1'b0;
    m_d     = 16'h0000;
    m_tx    = 0;
    m_ovf   = 1'b0;
    m_stall = 0;
    m_tmo   = 1'b0;
  endtask

  // One clock edge of the specified behaviour, from pre-edge state and inputs.
  task automatic model_step();
    bit was_full;
    bit xfer;
    was_full = (m_q.size() == DEPTH);
    xfer     = m_v && ready;
    m_ovf    = wr_en && was_full;
    if (xfer) m_tx = (m_tx + 1) % 65536;
    if (tmo_clr) begin
      m_stall = 0;
      m_tmo   = 1'b0;
    end else if (xfer) begin
      m_stall = 0;
    end else if (m_v) begin
      if (m_stall < TMO) m_stall++;
      if (m_stall == TMO) m_tmo = 1'b1;
    end
    if ((!m_v || xfer) && m_q.size() > 0) begin
      m_d = m_q.pop_front();
      m_v = 1'b1;
    end else if (xfer) begin
      m_v = 1'b0;
    end
    if (wr_en && !was_full) m_q.push_back(wr_data);
  endtask

  task automatic compare_all();
    check_eq("valid", 32'(valid), 32'(m_v));
    if (m_v) check_eq("data", 32'(data), 32'(m_d));
    check_eq("full", 32'(full), 32'(m_q.size() == DEPTH));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
    check_eq("level", 32'(level), 32'(m_q.size()));
    check_eq("tx_count", 32'(tx_count), 32'(m_tx));
    check_eq("timeout", 32'(timeout), 32'(m_tmo));
  endtask

  // Drive inputs, compare on the falling edge, advance model on the rising edge.
  task automatic cycle(input logic we, input logic [15:0] wd, input logic rdy,
                       input logic clr);
    wr_en   = we;
    wr_data = wd;
    ready   = rdy;
    tmo_clr = clr;
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 16'h0000;
    ready   = 1'b0;
    tmo_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: asynchronous reset while a word is on the wire
    cycle(1'b1, 16'h1234, 1'b0, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0);
    check_eq("t1_pre_valid", 32'(valid), 32'd1);
    check_eq("t1_pre_data", 32'(data), 32'h1234);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t1_rst_valid", 32'(valid), 32'd0);
    check_eq("t1_rst_data", 32'(data), 32'h0000);
    check_eq("t1_rst_level", 32'(level), 32'd0);
    check_eq("t1_rst_tx", 32'(tx_count), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 2: single word held through a stall, then one transfer
    cycle(1'b1, 16'hA5A5, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 16'h0000, 1'b0, 1'b0);
    check_eq("t2_hold_data", 32'(data), 32'hA5A5);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    check_eq("t2_tx", 32'(tx_count), 32'd1);
    check_eq("t2_valid_drop", 32'(valid), 32'd0);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0);

    // 3: back-to-back streaming with ready held high
    for (int i = 1; i <= 8; i++) cycle(1'b1, 16'(i), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    check_eq("t3_tx", 32'(tx_count), 32'd9);

    // 4: fill and overflow with ready low, then drain
    for (int i = 1; i <= 6; i++) cycle(1'b1, 16'h4000 + 16'(i), 1'b0, 1'b0);
    check_eq("t4_overflow", 32'(overflow), 32'd1);
    check_eq("t4_full", 32'(full), 32'd1);
    for (int i = 0; i < 7; i++) cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    check_eq("t4_tx", 32'(tx_count), 32'd14);

    // 5: write and transfer on the same edge at level 2
    for (int i = 1; i <= 3; i++) cycle(1'b1, 16'h5000 + 16'(i), 1'b0, 1'b0);
    check_eq("t5_level_pre", 32'(level), 32'd2);
    cycle(1'b1, 16'h5004, 1'b1, 1'b0);
    check_eq("t5_level_post", 32'(level), 32'd2);
    for (int i = 0; i < 6; i++) cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1);

    // 6: stall timeout, clear, then delivery
    cycle(1'b1, 16'hBEEF, 1'b0, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0);
    for (int i = 1; i <= TMO; i++) begin
      cycle(1'b0, 16'h0000, 1'b0, 1'b0);
      check_eq("t6_timeout", 32'(timeout), 32'(i == TMO));
    end
    check_eq("t6_valid_kept", 32'(valid), 32'd1);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1);
    check_eq("t6_cleared", 32'(timeout), 32'd0);
    check_eq("t6_data", 32'(data), 32'hBEEF);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0);

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 99) < 60), 16'($urandom), 1'($urandom_range(0, 99) < 45),
            1'($urandom_range(0, 99) < 3));
    end
    for (int i = 0; i < 8; i++) cycle(1'b0, 16'h0000, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
